// File: rtl/usb_tx_serializer.sv
// Byte-to-bit serializer for the USB full-speed transmit path: shifts packet bytes out LSB-first,
// appends CRC16 on request and sequences the downstream NRZI encoder's reset/done handshake.
module usb_tx_serializer #(
    parameter logic [15:0] CRC_INIT = 16'hFFFF,
    parameter logic [15:0] CRC_POLY = 16'h8005
) (
    input  logic       clk48,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    input  logic       crc16_en,
    output logic       tx_ready,
    output logic       bit_out,
    output logic       last_bit,
    input  logic       bit_ack,
    output logic       enc_reset,
    input  logic       enc_done,
    output logic       busy,
    output logic       pkt_done,
    output logic       err_underrun
);

    typedef enum logic [2:0] {
        StIdle, StPid, StData, StCrc, StAbort, StWaitDone
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  next_q, next_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        next_valid_q, next_valid_d;
    logic        last_taken_q, last_taken_d;
    logic        crc_en_q, crc_en_d;
    logic [15:0] crc_q, crc_d;
    logic [3:0]  crc_idx_q, crc_idx_d;
    logic        enc_reset_q, enc_reset_d;
    logic        busy_q, busy_d;
    logic        pkt_done_q, pkt_done_d;
    logic        err_q, err_d;
    logic        in_byte, accept, fb;

    always_comb begin
        in_byte  = (state_q == StPid) || (state_q == StData);
        tx_ready = !reset && ((state_q == StIdle) ||
                              (in_byte && !next_valid_q && !last_taken_q));
        accept   = tx_valid && tx_ready;
        case (state_q)
            StPid, StData: bit_out = shift_q[bit_idx_q];
            StCrc:         bit_out = ~crc_q[15];
            default:       bit_out = 1'b1;
        endcase
        fb       = bit_out ^ crc_q[15];
        last_bit = (in_byte && (bit_idx_q == 3'd7) && last_taken_q && !next_valid_q && !crc_en_q)
                || ((state_q == StCrc) && (crc_idx_q == 4'd15))
                || (state_q == StAbort);
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        next_d       = next_q;
        bit_idx_d    = bit_idx_q;
        next_valid_d = next_valid_q;
        last_taken_d = last_taken_q;
        crc_en_d     = crc_en_q;
        crc_d        = crc_q;
        crc_idx_d    = crc_idx_q;
        enc_reset_d  = enc_reset_q;
        busy_d       = busy_q;
        pkt_done_d   = 1'b0;
        err_d        = err_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d      = tx_data;
                    crc_en_d     = crc16_en;
                    last_taken_d = tx_last;
                    bit_idx_d    = 3'd0;
                    crc_d        = CRC_INIT;
                    err_d        = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = StPid;
                end
            end
            StPid, StData: begin
                // Release the encoder one cycle after the PID is taken so its reset spans >=2 cycles
                enc_reset_d = 1'b0;
                if (accept) begin
                    next_d       = tx_data;
                    next_valid_d = 1'b1;
                    last_taken_d = tx_last;
                end
                if (bit_ack) begin
                    if ((state_q == StData) && crc_en_q) begin
                        crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
                    end
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        if (last_taken_q && !next_valid_q) begin
                            crc_idx_d = 4'd0;
                            state_d   = crc_en_q ? StCrc : StWaitDone;
                        end else if (next_valid_q) begin
                            shift_d      = next_q;
                            next_valid_d = 1'b0;
                            state_d      = StData;
                        end else if (accept) begin
                            // Byte arriving on the boundary cycle skips the holding register
                            shift_d      = tx_data;
                            next_valid_d = 1'b0;
                            state_d      = StData;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StAbort;
                        end
                    end
                end
            end
            StCrc: begin
                if (bit_ack) begin
                    crc_d     = {crc_q[14:0], 1'b0};
                    crc_idx_d = crc_idx_q + 4'd1;
                    if (crc_idx_q == 4'd15) begin
                        state_d = StWaitDone;
                    end
                end
            end
            StAbort: begin
                if (bit_ack) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (enc_done) begin
                    enc_reset_d = 1'b1;
                    pkt_done_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            shift_q      <= 8'h00;
            next_q       <= 8'h00;
            bit_idx_q    <= 3'd0;
            next_valid_q <= 1'b0;
            last_taken_q <= 1'b0;
            crc_en_q     <= 1'b0;
            crc_q        <= CRC_INIT;
            crc_idx_q    <= 4'd0;
            enc_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            pkt_done_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            next_q       <= next_d;
            bit_idx_q    <= bit_idx_d;
            next_valid_q <= next_valid_d;
            last_taken_q <= last_taken_d;
            crc_en_q     <= crc_en_d;
            crc_q        <= crc_d;
            crc_idx_q    <= crc_idx_d;
            enc_reset_q  <= enc_reset_d;
            busy_q       <= busy_d;
            pkt_done_q   <= pkt_done_d;
            err_q        <= err_d;
        end
    end

    assign enc_reset    = enc_reset_q;
    assign busy         = busy_q;
    assign pkt_done     = pkt_done_q;
    assign err_underrun = err_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Bench for usb_tx_serializer: an encoder model acks every 4 cycles and records the bit stream,
// which is compared against a packet-level model of the expected line bits and CRC16.
module tb_usb_tx_serializer;

    logic       clk48 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0, tx_last = 1'b0, crc16_en = 1'b0;
    logic       bit_ack = 1'b0, enc_done = 1'b0;
    logic       tx_ready, bit_out, last_bit, enc_reset, busy, pkt_done, err_underrun;

    int checks = 0;
    int errors = 0;
    logic       got_bits[$];
    logic       got_last[$];
    logic       exp_bits[$];
    logic [7:0] pkt_q[$];
    int   ack_cnt = 0, done_cnt = 0, pkt_cnt = 0, p_start = 0;
    logic eop = 1'b0;

    usb_tx_serializer dut (
        .clk48(clk48), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_last(tx_last), .crc16_en(crc16_en), .tx_ready(tx_ready), .bit_out(bit_out),
        .last_bit(last_bit), .bit_ack(bit_ack), .enc_reset(enc_reset), .enc_done(enc_done),
        .busy(busy), .pkt_done(pkt_done), .err_underrun(err_underrun)
    );

    always #10 clk48 = ~clk48;

    // Encoder model: one ack per 4 cycles while out of reset, enc_done 3 cycles after the last bit
    always @(negedge clk48) begin
        bit_ack  = 1'b0;
        enc_done = 1'b0;
        if (reset || enc_reset) begin
            ack_cnt  = 0;
            done_cnt = 0;
            eop      = 1'b0;
        end else if (eop) begin
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) enc_done = 1'b1;
            end
        end else begin
            ack_cnt++;
            if (ack_cnt == 4) begin
                ack_cnt = 0;
                bit_ack = 1'b1;
                got_bits.push_back(bit_out);
                got_last.push_back(last_bit);
                if (last_bit) begin
                    eop      = 1'b1;
                    done_cnt = 3;
                end
            end
        end
        if (pkt_done) pkt_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic set_pkt(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        logic [7:0] b[5];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4;
        pkt_q.delete();
        for (int i = 0; i < n; i++) pkt_q.push_back(b[i]);
    endtask

    // Line bits: every byte LSB-first, then the complemented CRC16 of the post-PID bits, MSB-first
    task automatic build_exp(input logic ce);
        logic [15:0] c;
        logic        b;
        c = 16'hFFFF;
        exp_bits.delete();
        for (int k = 0; k < pkt_q.size(); k++) begin
            for (int i = 0; i < 8; i++) begin
                b = pkt_q[k][i];
                exp_bits.push_back(b);
                if (k > 0) c = {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
            end
        end
        if (ce) for (int i = 15; i >= 0; i--) exp_bits.push_back(~c[i]);
    endtask

    function automatic logic [15:0] residual();
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 8; i < got_bits.size(); i++)
            c = {c[14:0], 1'b0} ^ ((got_bits[i] ^ c[15]) ? 16'h8005 : 16'h0000);
        return c;
    endfunction

    task automatic push_byte(input logic [7:0] d, input logic last, input logic ce);
        int t;
        t = 0;
        tx_data  = d;
        tx_last  = last;
        crc16_en = ce;
        tx_valid = 1'b1;
        while (!tx_ready && t < 2000) begin
            @(negedge clk48);
            t++;
        end
        check("accept_in_time", 64'(t < 2000), 64'd1);
        @(negedge clk48);
        tx_valid = 1'b0;
    endtask

    task automatic start_packet(input logic ce, input logic final_last, input int n);
        got_bits.delete();
        got_last.delete();
        p_start = pkt_cnt;
        for (int k = 0; k < n; k++) begin
            push_byte(pkt_q[k], (k == pkt_q.size() - 1) ? final_last : 1'b0, ce);
            if (k == 1) check("ready_low_when_held", 64'(tx_ready), 64'd0);
        end
    endtask

    task automatic finish_packet(input string tag, input logic ce);
        int t;
        logic [63:0] gv, ev, gl, el;
        t = 0;
        while (pkt_cnt == p_start && t < 3000) begin
            @(negedge clk48);
            t++;
        end
        repeat (4) @(negedge clk48);
        check({tag, "_pkt_done_count"}, 64'(pkt_cnt - p_start), 64'd1);
        check({tag, "_idle"}, {62'd0, busy, enc_reset}, 64'd1);
        gv = '0; ev = '0; gl = '0; el = '0;
        for (int i = 0; i < got_bits.size() && i < 64; i++) begin
            gv[i] = got_bits[i];
            gl[i] = got_last[i];
        end
        for (int i = 0; i < exp_bits.size() && i < 64; i++) ev[i] = exp_bits[i];
        if (exp_bits.size() > 0) el[exp_bits.size() - 1] = 1'b1;
        check({tag, "_ack_count"}, 64'(got_bits.size()), 64'(exp_bits.size()));
        check({tag, "_bits"}, gv, ev);
        check({tag, "_last_bit"}, gl, el);
        if (ce) check({tag, "_crc_residual"}, {48'd0, residual()}, 64'h800D);
    endtask

    initial begin
        int t;
        int n;
        logic ce;
        repeat (3) @(negedge clk48);
        check("rst_tx_ready", 64'(tx_ready), 64'd0);
        check("rst_enc_reset", 64'(enc_reset), 64'd1);
        check("rst_bit_out", 64'(bit_out), 64'd1);
        check("rst_outs_low", {60'd0, last_bit, busy, pkt_done, err_underrun}, 64'd0);
        reset = 1'b0;
        @(negedge clk48);
        check("idle_ready", 64'(tx_ready), 64'd1);

        // ACK handshake packet, no CRC
        set_pkt(1, 8'hD2, 0, 0, 0, 0); build_exp(1'b0);
        start_packet(1'b0, 1'b1, 1);
        finish_packet("ack", 1'b0);

        // Zero-length DATA0 with CRC
        set_pkt(1, 8'hC3, 0, 0, 0, 0); build_exp(1'b1);
        start_packet(1'b1, 1'b1, 1);
        finish_packet("zlp", 1'b1);

        // Streamed DATA1 with four payload bytes
        set_pkt(5, 8'h4B, 8'h00, 8'h01, 8'h02, 8'h03); build_exp(1'b1);
        start_packet(1'b1, 1'b1, 5);
        finish_packet("data1", 1'b1);
        check("data1_no_underrun", 64'(err_underrun), 64'd0);

        // Underrun: second byte never arrives
        set_pkt(1, 8'hC3, 0, 0, 0, 0); build_exp(1'b0); exp_bits.push_back(1'b1);
        start_packet(1'b1, 1'b0, 1);
        t = 0;
        while (got_bits.size() < 8 && t < 1000) begin
            @(negedge clk48); #1;
            t++;
        end
        @(posedge clk48); #1;
        check("abort_outputs", {61'd0, bit_out, last_bit, err_underrun}, 64'h7);
        finish_packet("abort", 1'b0);
        check("underrun_sticky", 64'(err_underrun), 64'd1);

        // Second byte offered on the very cycle of the 8th PID ack
        set_pkt(2, 8'h4B, 8'hA5, 0, 0, 0); build_exp(1'b0);
        start_packet(1'b0, 1'b0, 1);
        check("underrun_cleared", 64'(err_underrun), 64'd0);
        t = 0;
        while (t < 1000) begin
            @(negedge clk48); #1;
            if (bit_ack && got_bits.size() == 8) break;
            t++;
        end
        push_byte(8'hA5, 1'b1, 1'b0);
        finish_packet("bypass", 1'b0);
        check("bypass_no_underrun", 64'(err_underrun), 64'd0);

        // Reset while CRC bits are going out
        set_pkt(3, 8'hC3, 8'h11, 8'h22, 0, 0); build_exp(1'b1);
        start_packet(1'b1, 1'b1, 3);
        t = 0;
        while (got_bits.size() < 27 && t < 2000) begin
            @(negedge clk48);
            t++;
        end
        reset = 1'b1;
        #1;
        check("midrst_outputs", {60'd0, enc_reset, busy, last_bit, bit_out}, 64'h9);
        repeat (2) @(negedge clk48);
        reset = 1'b0;
        @(negedge clk48);
        set_pkt(2, 8'h4B, 8'h5A, 0, 0, 0); build_exp(1'b1);
        start_packet(1'b1, 1'b1, 2);
        finish_packet("post_reset", 1'b1);

        // Randomized packets
        for (int r = 0; r < 6; r++) begin
            n  = $urandom_range(1, 5);
            ce = 1'(n == 1 ? 1 : $urandom_range(0, 1));
            set_pkt(n, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            build_exp(ce);
            start_packet(ce, 1'b1, n);
            finish_packet($sformatf("rand%0d", r), ce);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
